// File: rtl/dsp_axis_pkg.sv
// dsp_axis_pkg: constants shared by the DSP operand transmitter, the multiplier and their benches.
package dsp_axis_pkg;
   localparam int WIDTH   = 16;
   localparam int LANE_A  = 0;
   localparam int LANE_B  = 1;
   localparam int LANE_C  = 2;
   localparam int COUNT_W = 32;
endpackage

// File: rtl/dsp_axis_sync_fifo.sv
// dsp_axis_sync_fifo: single-clock FIFO; an extra pointer MSB tells full from empty.
module dsp_axis_sync_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      level_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic push, pop;
   assign push      = wr_en_i && !full_o;
   assign pop       = rd_en_i && !empty_o;
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = wr_ptr_q == rd_ptr_q;
   assign level_o   = wr_ptr_q - rd_ptr_q;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   // Storage needs no reset: entries are only visible between valid pointers.
   always_ff @(posedge clk)
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
endmodule

// File: rtl/dsp_axis_tri_source.sv
// dsp_axis_tri_source: buffers packed a/b/c triples and forks each onto three AXI-stream
// channels; the next triple loads only once every channel has accepted the current one.
module dsp_axis_tri_source
   import dsp_axis_pkg::*;
#(
   parameter int WIDTH = dsp_axis_pkg::WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3*WIDTH-1:0]      input_tdata,
   input  logic                    input_tvalid,
   output logic                    input_tready,
   output logic [WIDTH-1:0]        output_a_tdata,
   output logic [WIDTH-1:0]        output_b_tdata,
   output logic [WIDTH-1:0]        output_c_tdata,
   output logic                    output_a_tvalid,
   output logic                    output_b_tvalid,
   output logic                    output_c_tvalid,
   input  logic                    output_a_tready,
   input  logic                    output_b_tready,
   input  logic                    output_c_tready,
   output logic [COUNT_W-1:0]      word_count,
   output logic [$clog2(DEPTH):0]  fifo_level
);
   logic [3*WIDTH-1:0] head, data_q, data_d;
   logic [2:0] pend_q, pend_d, ready, remaining;
   logic [COUNT_W-1:0] count_q, count_d;
   logic full, empty, load;
   dsp_axis_sync_fifo #(.WIDTH(3*WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (input_tvalid && input_tready),
      .wr_data_i (input_tdata),
      .rd_en_i   (load),
      .rd_data_o (head),
      .full_o    (full),
      .empty_o   (empty),
      .level_o   (fifo_level)
   );
   assign input_tready = !full && !rst;
   assign ready = {output_c_tready, output_b_tready, output_a_tready};
   // remaining==0 covers both an idle fork and one whose last pending lanes accept now.
   always_comb begin
      remaining = pend_q & ~ready;
      load      = !empty && remaining == 3'b000;
      pend_d    = load ? 3'b111 : remaining;
      data_d    = load ? head : data_q;
      count_d   = (pend_q != 3'b000 && remaining == 3'b000) ? count_q + COUNT_W'(1) : count_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pend_q  <= '0;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         pend_q  <= pend_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   assign output_a_tdata  = data_q[LANE_A*WIDTH +: WIDTH];
   assign output_b_tdata  = data_q[LANE_B*WIDTH +: WIDTH];
   assign output_c_tdata  = data_q[LANE_C*WIDTH +: WIDTH];
   assign output_a_tvalid = pend_q[LANE_A];
   assign output_b_tvalid = pend_q[LANE_B];
   assign output_c_tvalid = pend_q[LANE_C];
   assign word_count      = count_q;
endmodule

// File: tb/tb_dsp_axis_tri_source.sv
// tb_dsp_axis_tri_source: directed scenarios for the three-lane operand transmitter.
module tb_dsp_axis_tri_source;
   localparam int W = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3*W-1:0] input_tdata = '0;
   logic input_tvalid = 1'b0;
   logic input_tready;
   logic [W-1:0] a_d, b_d, c_d;
   logic a_v, b_v, c_v;
   logic a_r = 1'b1, b_r = 1'b1, c_r = 1'b1;
   logic [31:0] word_count;
   logic [2:0] fifo_level;
   int checks = 0;
   int failures = 0;

   dsp_axis_tri_source #(.WIDTH(W), .DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .input_tdata     (input_tdata),
      .input_tvalid    (input_tvalid),
      .input_tready    (input_tready),
      .output_a_tdata  (a_d),
      .output_b_tdata  (b_d),
      .output_c_tdata  (c_d),
      .output_a_tvalid (a_v),
      .output_b_tvalid (b_v),
      .output_c_tvalid (c_v),
      .output_a_tready (a_r),
      .output_b_tready (b_r),
      .output_c_tready (c_r),
      .word_count      (word_count),
      .fifo_level      (fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [3*W-1:0] pack3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      return {c, b, a};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      input_tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", {a_v, b_v, c_v}); end
      checks++;
      if ({a_d, b_d, c_d} !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", {a_d, b_d, c_d}); end
      checks++;
      if (word_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", word_count); end
      checks++;
      if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++;
      if (input_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", input_tready); end
      rst = 1'b0;
      #1;
      checks++;
      if (input_tready !== 1'b1) begin failures++; $display("FAIL release_tready got=%b exp=1", input_tready); end
   endtask

   task automatic test_single();
      input_tdata = pack3(16'd1, 16'd2, 16'd3);
      input_tvalid = 1'b1;
      @(posedge clk); #1;
      input_tvalid = 1'b0;
      checks++;
      if ({a_v, b_v, c_v, fifo_level} !== {3'b000, 3'd1}) begin failures++; $display("FAIL single_push valid=%b level=%0d exp valid=000 level=1", {a_v, b_v, c_v}, fifo_level); end
      @(posedge clk); #1;
      checks++;
      if ({a_v, b_v, c_v} !== 3'b111) begin failures++; $display("FAIL single_valid got=%b exp=111", {a_v, b_v, c_v}); end
      checks++;
      if ({a_d, b_d, c_d} !== {16'd1, 16'd2, 16'd3}) begin failures++; $display("FAIL single_data got=%h/%h/%h exp=1/2/3", a_d, b_d, c_d); end
      checks++;
      if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level got=%0d exp=0", fifo_level); end
      @(posedge clk); #1;
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000) begin failures++; $display("FAIL single_drop got=%b exp=000", {a_v, b_v, c_v}); end
      checks++;
      if (word_count !== 32'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", word_count); end
   endtask

   task automatic test_stream();
      for (int n = 1; n <= 11; n++) begin
         input_tvalid = n <= 10;
         input_tdata = pack3(W'(n), W'(2*n), W'(3*n));
         @(posedge clk); #1;
         if (n >= 2) begin
            checks++;
            if ({a_v, b_v, c_v, a_d, b_d, c_d} !== {3'b111, W'(n-1), W'(2*(n-1)), W'(3*(n-1))})
               begin failures++; $display("FAIL stream_%0d got v=%b %0d/%0d/%0d exp v=111 %0d/%0d/%0d", n-1, {a_v, b_v, c_v}, a_d, b_d, c_d, n-1, 2*(n-1), 3*(n-1)); end
         end
      end
      input_tvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000) begin failures++; $display("FAIL stream_end_valid got=%b exp=000", {a_v, b_v, c_v}); end
      checks++;
      if (word_count !== 32'd11) begin failures++; $display("FAIL stream_count got=%0d exp=11", word_count); end
   endtask

   task automatic test_backpressure();
      int p = 1;
      logic pushed;
      b_r = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         if (e == 9) begin
            b_r = 1'b1;
            input_tvalid = 1'b0;
         end else begin
            input_tdata = pack3(W'(p), W'(2*p), W'(3*p));
            input_tvalid = 1'b1;
         end
         pushed = input_tvalid && input_tready;
         @(posedge clk); #1;
         if (pushed) p++;
         if (e == 2) begin
            checks++;
            if ({a_v, b_v, c_v, a_d, b_d, c_d} !== {3'b111, 16'd1, 16'd2, 16'd3}) begin failures++; $display("FAIL bp_load got v=%b %0d/%0d/%0d exp v=111 1/2/3", {a_v, b_v, c_v}, a_d, b_d, c_d); end
         end
         if (e >= 3 && e <= 8) begin
            checks++;
            if ({a_v, b_v, c_v, b_d} !== {3'b010, 16'd2}) begin failures++; $display("FAIL bp_hold_e%0d got v=%b b=%0d exp v=010 b=2", e, {a_v, b_v, c_v}, b_d); end
         end
         if (e >= 5 && e <= 8) begin
            checks++;
            if ({fifo_level, input_tready} !== {3'd4, 1'b0}) begin failures++; $display("FAIL bp_full_e%0d got level=%0d tready=%b exp level=4 tready=0", e, fifo_level, input_tready); end
         end
      end
      checks++;
      if ({a_v, b_v, c_v, a_d, b_d, c_d} !== {3'b111, 16'd2, 16'd4, 16'd6}) begin failures++; $display("FAIL bp_release got v=%b %0d/%0d/%0d exp v=111 2/4/6", {a_v, b_v, c_v}, a_d, b_d, c_d); end
      checks++;
      if ({word_count, fifo_level} !== {32'd12, 3'd3}) begin failures++; $display("FAIL bp_release_cnt got count=%0d level=%0d exp count=12 level=3", word_count, fifo_level); end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if ({word_count, fifo_level, a_v, b_v, c_v} !== {32'd16, 3'd0, 3'b000}) begin failures++; $display("FAIL bp_drain got count=%0d level=%0d v=%b exp count=16 level=0 v=000", word_count, fifo_level, {a_v, b_v, c_v}); end
   endtask

   task automatic test_midreset();
      b_r = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         input_tdata = pack3(W'(16 + e), W'(32 + e), W'(48 + e));
         input_tvalid = 1'b1;
         @(posedge clk); #1;
      end
      input_tvalid = 1'b0;
      checks++;
      if ({fifo_level, a_v, b_v, c_v} !== {3'd3, 3'b010}) begin failures++; $display("FAIL mr_setup got level=%0d v=%b exp level=3 v=010", fifo_level, {a_v, b_v, c_v}); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a_v, b_v, c_v} !== 3'b000) begin failures++; $display("FAIL mr_valid got=%b exp=000", {a_v, b_v, c_v}); end
      checks++;
      if ({a_d, b_d, c_d} !== '0) begin failures++; $display("FAIL mr_data got=%h exp=0", {a_d, b_d, c_d}); end
      checks++;
      if ({word_count, fifo_level, input_tready} !== {32'd0, 3'd0, 1'b0}) begin failures++; $display("FAIL mr_state got count=%0d level=%0d tready=%b exp 0/0/0", word_count, fifo_level, input_tready); end
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      b_r = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         checks++;
         if ({a_v, b_v, c_v, fifo_level} !== {3'b000, 3'd0}) begin failures++; $display("FAIL mr_quiet_%0d got v=%b level=%0d exp v=000 level=0", n, {a_v, b_v, c_v}, fifo_level); end
      end
   endtask

   task automatic test_extreme();
      input_tdata = pack3(16'hFFFF, 16'h0000, 16'h8000);
      input_tvalid = 1'b1;
      @(posedge clk); #1;
      input_tvalid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({a_v, b_v, c_v, a_d, b_d, c_d} !== {3'b111, 16'hFFFF, 16'h0000, 16'h8000}) begin failures++; $display("FAIL extreme_data got v=%b %h/%h/%h exp v=111 ffff/0000/8000", {a_v, b_v, c_v}, a_d, b_d, c_d); end
      @(posedge clk); #1;
      checks++;
      if ({word_count, a_v, b_v, c_v} !== {32'd1, 3'b000}) begin failures++; $display("FAIL extreme_count got count=%0d v=%b exp count=1 v=000", word_count, {a_v, b_v, c_v}); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_midreset();
      test_extreme();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dsp_axis_tri_source.md
# dsp_axis_tri_source

Synthesizable three-channel AXI-stream transmitter that feeds the `a`/`b`/`c` operand ports of the DSP multiplier datapath. It accepts one packed operand triple per input handshake and buffers it in a small FIFO. It then fans each triple out onto three independent AXI-stream channels. Each channel completes its handshake on its own `tready`. The next triple is presented only after all three channels have accepted the current one.

## Interface
Parameters:
- `WIDTH`, 16: operand width per channel.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `input_tdata`  in  3*WIDTH  packed triple: [WIDTH-1:0]=a, [2W-1:W]=b, [3W-1:2W]=c.
- `input_tvalid`  in  1  upstream triple valid.
- `input_tready`  out  1  = !fifo_full && !rst.
- `output_a_tdata` / `output_b_tdata` / `output_c_tdata`  out  WIDTH  operand data.
- `output_a_tvalid` / `output_b_tvalid` / `output_c_tvalid`  out  1  per-channel valid.
- `output_a_tready` / `output_b_tready` / `output_c_tready`  in  1  per-channel ready.
- `word_count`  out  32  triples fully dispatched since reset; wraps 0xFFFFFFFF→0.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values.** All `*_tvalid`=0, all `*_tdata`=0, `word_count`=0, `fifo_level`=0, pend_a/b/c=0.
- **Input side.** A push occurs on `input_tvalid && input_tready`. While the FIFO is full, `input_tready`=0 even if a pop happens in the same cycle; there is no full pass-through.
- **Fork stage.** The fork stage holds data registers and pend_a/b/c flags. `output_x_tvalid` = pend_x.
- **Fork states.**
  - IDLE: all pend flags are 0.
  - BUSY: at least one pend flag is 1.
- **Load.** A load happens at an edge when the FIFO is non-empty and the fork stage is either IDLE or completing. Completing means every set pend_x is accepted (`tvalid && tready`) in that cycle. A load pops the FIFO head into the data registers and sets all three pend flags to 1.
- **Per-channel handshake.** On `tvalid && tready`, pend_x clears. Other channels are unaffected. Data on any channel stays stable while its tvalid is high.
- **Counting.** `word_count` increments once, on the cycle the last pend flag of a triple clears. This applies whether the three channels complete together or on separate cycles.
- **No overlap.** A channel never sees triple n+1 before all three channels have accepted triple n.
- **Simultaneous push and pop.** The FIFO level is unchanged and the pointers both advance.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer MSB.
- **Reset mid-operation.** All outputs deassert asynchronously. FIFO contents and the in-flight triple are discarded and are not replayed after release.

## Timing
- **Latency.** A triple accepted at edge k into an empty FIFO with IDLE fork is loaded at edge k+1. All three tvalid rise after edge k+1.
- **Throughput.** With all three treadys held high, one triple per cycle is dispatched with no bubbles.
- **Independent completion.** Channels complete independently. A stalled channel holds data and tvalid. The other channels drop tvalid after their own accept edge.
- **fifo_level timing.** `fifo_level` updates at the same edge as the push or pop.
- **input_tready.** `input_tready` is combinational from registered full state plus `rst`. There is no path from `output_*_tready` to `input_tready`.

## Structure
- Shared package `dsp_axis_pkg` contains:
  - default `WIDTH`;
  - lane offset constants `LANE_A`=0, `LANE_B`=1, `LANE_C`=2;
  - the `COUNT_W`=32 constant.
  - The DSP multiplier and its benches import the same package.
- Sub-module `dsp_axis_sync_fifo` (WIDTH=3*WIDTH, DEPTH): a single-clock FIFO with async reset, exposing full, empty and level.
- The fork stage and counter live in the top module.

## Test plan
1. **Reset.** Hold `rst` for 3 cycles → all tvalid=0, all tdata=0, `word_count`=0, `fifo_level`=0, `input_tready`=0. After release → `input_tready`=1.
2. **Single triple.** Push a=1, b=2, c=3 at edge k with all treadys=1 → a/b/c tvalid are high for exactly the one cycle after edge k+1, carrying 1/2/3. `word_count`=1.
3. **Streaming.** Push 10 consecutive triples (a=i, b=2i, c=3i, i=1..10) with all treadys high → 10 back-to-back valid cycles in order, no gaps, `word_count`=10.
4. **Backpressure and fill.**
   - Stimulus: hold `output_b_tready` low for 8 cycles while pushing continuously.
   - Response: a and c accept triple 1 then drop tvalid, while b holds value 2 stable.
   - FIFO reaches `fifo_level`=4, then `input_tready`=0.
   - Releasing b → the next triple loads in the same cycle and `word_count` increments by 1.
5. **Reset mid-flight.** Assert `rst` with `fifo_level`=3 and pend_b=1 → all outputs clear immediately. After release nothing is emitted until new pushes arrive.
6. **Extreme values.** Push a=16'hFFFF, b=16'h0000, c=16'h8000 → values pass through bit-exact on their correct lanes.
